mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative MIPS multiply/divide unit with architectural HI/LO registers.
//  Takes operands from the register file read ports (RD1 -> src_a, RD2 -> src_b).
//  Returns MFHI/MFLO data toward the write-back mux that drives register-file WD3.
//  Raises stall so the pipeline holds an instruction that depends on an unfinished operation.
// PARAMETERS
//  DATA_W   32   operand width and HI/LO width; only 32 is supported
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       asynchronous, active-low; clears all state
//  start    in   1       operation request, sampled on the rising edge
//  op       in   3       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//  src_a    in   DATA_W  rs operand (multiplicand / dividend / MTHI/MTLO data)
//  src_b    in   DATA_W  rt operand (multiplier / divisor)
//  mf_req   in   1       an MFHI/MFLO instruction is in decode
//  mf_hi    in   1       1 = read HI, 0 = read LO
//  mf_data  out  DATA_W  combinational: mf_hi ? hi : lo
//  hi       out  DATA_W  HI register
//  lo       out  DATA_W  LO register
//  busy     out  1       an operation is in progress
//  done     out  1       one-cycle pulse when HI/LO take the new result
//  stall    out  1       combinational: busy & (mf_req | start)
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy=0, done=0; state IDLE; counter=0; all work registers 0.
//    Asserting reset mid-operation aborts the operation; HI/LO are not updated.
//  - FSM IDLE -> RUN -> FIX -> IDLE.
//    - IDLE, start & op in {MULT, MULTU, DIV, DIVU}:
//      - latch operand magnitudes; signed ops take abs() and record sign_q=a^b, sign_r=a.
//      - counter=0; go to RUN; busy=1 from the next cycle.
//    - IDLE, start & MTHI/MTLO: write hi/lo at that edge; busy and done stay 0.
//    - IDLE, start & op 11x: no effect.
//    - RUN: exactly 32 edges, one bit per edge.
//      - multiply: shift-add, 64-bit product accumulator.
//      - divide: restoring, 33-bit partial remainder.
//      - after 32 edges go to FIX.
//    - FIX (1 edge):
//      - apply sign correction (two's-complement negate where the recorded sign is set).
//      - write hi/lo; busy=0; done=1 for the following cycle; go to IDLE.
//  - Latency, iterative: start sampled at edge E0; RUN covers E1..E32; FIX at E33.
//    busy is high E0+..E33-; new hi/lo and done=1 visible after E33.
//  - Results:
//    - MULT/MULTU: {hi,lo} = 64-bit product.
//    - DIV/DIVU: lo = quotient, hi = remainder; remainder takes the dividend's sign.
//  - Divide by zero, no trap:
//    - DIVU: lo=32'hFFFFFFFF, hi=src_a.
//    - DIV: magnitude result, then sign correction.
//  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
//  - start while busy: ignored (stall=1 holds the instruction until busy falls); no queueing.
//  - start in the cycle done=1 (state IDLE): accepted normally.
//  - mf_data always reflects the current hi/lo.
//    While busy these are stale; the consumer must honour stall.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined:
//    - MULT/MULTU are single-cycle: {hi,lo} written at E0; done=1 after E0; busy never set.
//    - DIV/DIVU remain iterative.
//  MDU_FAST_MUL_EN undefined: every multiply takes the 33-edge iterative path above.
// TESTING
//  1. reset low mid-RUN of a DIVU -> busy=0, done=0, hi=lo=0 immediately; no later done pulse.
//  2. MULTU FFFFFFFF*FFFFFFFF -> after E33 hi=FFFFFFFE, lo=00000001.
//     busy high for exactly 33 cycles; done pulses once.
//     With MDU_FAST_MUL_EN: same values after E0, busy never high.
//  3. MULT FFFFFFFD(-3)*00000007 -> hi=FFFFFFFF, lo=FFFFFFEB.
//     DIV FFFFFFF9(-7)/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  4. DIVU 00000064/00000000 -> lo=FFFFFFFF, hi=00000064.
//     DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000.
//  5. During busy: mf_req=1 -> stall=1 until busy falls.
//     A second start with MTLO 1234 while busy -> ignored; lo holds the divide result.
//  6. Back-to-back: MTHI 0000ABCD -> hi=0000ABCD next cycle, busy=0, done=0.
//     Then a MULTU started in the done cycle of a prior op -> accepted with correct latency.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Bus bundle between the pipeline and the MIPS multiply/divide unit.
// The pipeline side uses the master modport; the unit uses the slave modport.
`timescale 1ns/1ps
interface mul_div_unit_if #(parameter int DATA_W = 32);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              mf_req;
  logic              mf_hi;
  logic [DATA_W-1:0] mf_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              stall;

  modport master (
    output start, op, src_a, src_b, mf_req, mf_hi,
    input  mf_data, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, src_a, src_b, mf_req, mf_hi,
    output mf_data, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Multiplies use a shift-add accumulator and divides a restoring divider, both on
// magnitudes, one bit per clock, followed by a single sign-fix cycle.
// Optional feature macro: MDU_FAST_MUL_EN makes MULT/MULTU single-cycle
// (HI/LO written on the accepting edge); divides stay iterative either way.
`timescale 1ns/1ps
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]    counter;
  logic                is_div;
  logic                sign_q;
  logic                sign_r;
  logic                done_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   divisor;

  logic                accept;
  logic                arith_op;
  logic                signed_op;
  logic                launch_iter;
  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic                new_sign_q;
  logic                new_sign_r;

  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff;

  logic [2*DATA_W-1:0] prod_fixed;
  logic [DATA_W-1:0]   quot_fixed;
  logic [DATA_W-1:0]   rem_fixed;

  // Request decode: requests only count while idle; op[0]=1 marks the unsigned variants.
  assign accept     = bus.start && (state == IDLE);
  assign arith_op   = ~bus.op[2];
  assign signed_op  = ~bus.op[0];
  assign abs_a      = (signed_op && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
  assign abs_b      = (signed_op && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;
  assign new_sign_q = signed_op & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
  assign new_sign_r = signed_op & bus.src_a[DATA_W-1];

`ifdef MDU_FAST_MUL_EN
  logic                fast_mul;
  logic [2*DATA_W-1:0] fast_prod_mag;
  logic [2*DATA_W-1:0] fast_prod;

  assign fast_mul      = accept && arith_op && !bus.op[1];
  assign launch_iter   = accept && arith_op && bus.op[1];
  assign fast_prod_mag = {{DATA_W{1'b0}}, abs_a} * {{DATA_W{1'b0}}, abs_b};
  assign fast_prod     = new_sign_q ? -fast_prod_mag : fast_prod_mag;
`else
  assign launch_iter = accept && arith_op;
`endif

  // One multiply step: add the multiplicand into the upper half when the low bit is set, then shift right.
  assign mul_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, mcand};
  assign mul_next = prod[0] ? {mul_sum, prod[DATA_W-1:1]} : {1'b0, prod[2*DATA_W-1:1]};

  // One restoring-divide step on the 33-bit shifted partial remainder; a zero divisor yields all-ones quotient.
  assign div_shift = {rem, quot[DATA_W-1]};
  assign div_ge    = div_shift >= {1'b0, divisor};
  assign div_diff  = div_shift[DATA_W-1:0] - divisor;

  // Sign correction: quotient/product take sign_q, remainder takes the dividend's sign.
  assign prod_fixed = sign_q ? -prod : prod;
  assign quot_fixed = sign_q ? -quot : quot;
  assign rem_fixed  = sign_r ? -rem : rem;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> RUN on an iterative request, RUN for DATA_W steps, then one FIX cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch_iter) state_next = RUN;
      RUN:     if (counter == LAST_STEP) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: HI/LO writes, operand latching, per-step iteration and the final sign-fixed result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      is_div  <= 1'b0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod    <= '0;
      mcand   <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept && bus.op == OP_MTHI) hi_q <= bus.src_a;
      if (accept && bus.op == OP_MTLO) lo_q <= bus.src_a;
`ifdef MDU_FAST_MUL_EN
      if (fast_mul) begin
        {hi_q, lo_q} <= fast_prod;
        done_q       <= 1'b1;
      end
`endif
      if (launch_iter) begin
        counter <= '0;
        is_div  <= bus.op[1];
        sign_q  <= new_sign_q;
        sign_r  <= new_sign_r;
        if (bus.op[1]) begin
          rem     <= '0;
          quot    <= abs_a;
          divisor <= abs_b;
        end else begin
          prod  <= {{DATA_W{1'b0}}, abs_b};
          mcand <= abs_a;
        end
      end
      if (state == RUN) begin
        counter <= counter + CNT_W'(1);
        if (is_div) begin
          rem  <= div_ge ? div_diff : div_shift[DATA_W-1:0];
          quot <= {quot[DATA_W-2:0], div_ge};
        end else begin
          prod <= mul_next;
        end
      end
      if (state == FIX) begin
        if (is_div) begin
          hi_q <= rem_fixed;
          lo_q <= quot_fixed;
        end else begin
          {hi_q, lo_q} <= prod_fixed;
        end
        done_q <= 1'b1;
      end
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);
  assign bus.stall   = bus.busy & (bus.mf_req | bus.start);
  assign bus.mf_data = bus.mf_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized
// multiplies/divides compared against an arithmetic reference model.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
`timescale 1ns/1ps
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mul_div_unit_if #(.DATA_W(32)) bus_if ();

  mul_div_unit #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: {hi, lo} from the arithmetic definition of each operation.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    case (op)
      OP_MULT: begin
        ps = longint'(sa) * longint'(sb);
        return ps;
      end
      OP_MULTU: begin
        pu = 64'(a) * 64'(b);
        return pu;
      end
      OP_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) begin
          q = a[31] ? 32'd1 : 32'hFFFFFFFF;
          return {a, q};
        end
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request for one rising edge; called at a falling edge, returns just after the edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.src_a = a;
    bus_if.src_b = b;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.op    = OP_NOP;
  endtask

  // Wait (bounded) for the done pulse, counting falling edges on which busy was high.
  task automatic wait_done(output int busy_cycles, output int seen);
    busy_cycles = 0;
    seen        = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) begin
        seen = 1;
        break;
      end
      if (bus_if.busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int          cyc, seen;
    exp = model(op, a, b);
    apply_stimulus(op, a, b);
    wait_done(cyc, seen);
    check_output({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_output({tag, "_latency"}, 64'(cyc), 64'(op[1] ? DIV_LAT : MUL_LAT));
    check_output({tag, "_hi"}, 64'(bus_if.hi), 64'(exp[63:32]));
    check_output({tag, "_lo"}, 64'(bus_if.lo), 64'(exp[31:0]));
    @(negedge clk);
    check_output({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          cyc, seen, consumed, pulses;

    reset         = 1'b0;
    bus_if.start  = 1'b0;
    bus_if.op     = OP_NOP;
    bus_if.src_a  = '0;
    bus_if.src_b  = '0;
    bus_if.mf_req = 1'b0;
    bus_if.mf_hi  = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_hi", 64'(bus_if.hi), 64'd0);
    check_output("reset_lo", 64'(bus_if.lo), 64'd0);
    check_output("reset_busy", 64'(bus_if.busy), 64'd0);
    check_output("reset_done", 64'(bus_if.done), 64'd0);
    check_output("reset_stall", 64'(bus_if.stall), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] directed multiply/divide cases");
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    check_output("multu_max_const", {bus_if.hi, bus_if.lo}, 64'hFFFFFFFE_00000001);
    run_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, "mult_neg");
    check_output("mult_neg_const", {bus_if.hi, bus_if.lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, "div_neg");
    check_output("div_neg_const", {bus_if.hi, bus_if.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(OP_DIVU, 32'h00000064, 32'h00000000, "divu_zero");
    check_output("divu_zero_const", {bus_if.hi, bus_if.lo}, 64'h00000064_FFFFFFFF);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check_output("div_ovf_const", {bus_if.hi, bus_if.lo}, 64'h00000000_80000000);
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h00000000, "div_zero");
    check_output("div_zero_const", {bus_if.hi, bus_if.lo}, 64'hFFFFFFF9_00000001);

    $display("[TB] randomized operations");
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("[TB] stall and ignored start while busy");
    exp = model(OP_DIVU, 32'd1000, 32'd7);
    apply_stimulus(OP_DIVU, 32'd1000, 32'd7);
    bus_if.mf_req = 1'b1;
    consumed = 0;
    repeat (4) begin
      @(negedge clk);
      consumed++;
      check_output("stall_mf_req", 64'(bus_if.stall), 64'd1);
    end
    bus_if.start = 1'b1;
    bus_if.op    = OP_MTLO;
    bus_if.src_a = 32'h00001234;
    #1;
    check_output("stall_start", 64'(bus_if.stall), 64'd1);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.op    = OP_NOP;
    wait_done(cyc, seen);
    check_output("stall_done_seen", 64'(seen), 64'd1);
    check_output("stall_latency", 64'(consumed + cyc), 64'(DIV_LAT));
    check_output("stall_lo_kept", 64'(bus_if.lo), 64'(exp[31:0]));
    check_output("stall_hi", 64'(bus_if.hi), 64'(exp[63:32]));
    check_output("stall_released", 64'(bus_if.stall), 64'd0);
    check_output("mf_data_lo", 64'(bus_if.mf_data), 64'(exp[31:0]));
    bus_if.mf_hi = 1'b1;
    #1;
    check_output("mf_data_hi", 64'(bus_if.mf_data), 64'(exp[63:32]));
    bus_if.mf_req = 1'b0;
    bus_if.mf_hi  = 1'b0;
    @(negedge clk);

    $display("[TB] MTHI and back-to-back start");
    apply_stimulus(OP_MTHI, 32'h0000ABCD, 32'h0);
    @(negedge clk);
    check_output("mthi_hi", 64'(bus_if.hi), 64'h0000ABCD);
    check_output("mthi_lo_kept", 64'(bus_if.lo), 64'(exp[31:0]));
    check_output("mthi_busy", 64'(bus_if.busy), 64'd0);
    check_output("mthi_done", 64'(bus_if.done), 64'd0);
    apply_stimulus(OP_MTLO, 32'h00005678, 32'h0);
    @(negedge clk);
    check_output("mtlo_lo", 64'(bus_if.lo), 64'h00005678);

    ra  = $urandom;
    rb  = 32'($urandom_range(1, 1000));
    exp = model(OP_DIVU, ra, rb);
    apply_stimulus(OP_DIVU, ra, rb);
    wait_done(cyc, seen);
    check_output("b2b_div_seen", 64'(seen), 64'd1);
    check_output("b2b_div_result", {bus_if.hi, bus_if.lo}, exp);
    ra  = $urandom;
    rb  = $urandom;
    exp = model(OP_MULTU, ra, rb);
    apply_stimulus(OP_MULTU, ra, rb);
    wait_done(cyc, seen);
    check_output("b2b_mul_seen", 64'(seen), 64'd1);
    check_output("b2b_mul_latency", 64'(cyc), 64'(MUL_LAT));
    check_output("b2b_mul_result", {bus_if.hi, bus_if.lo}, exp);
    @(negedge clk);

    $display("[TB] reset during a divide");
    apply_stimulus(OP_DIVU, 32'hDEADBEEF, 32'd3);
    repeat (10) @(negedge clk);
    check_output("abort_busy_before", 64'(bus_if.busy), 64'd1);
    reset = 1'b0;
    #1;
    check_output("abort_busy", 64'(bus_if.busy), 64'd0);
    check_output("abort_done", 64'(bus_if.done), 64'd0);
    check_output("abort_hi", 64'(bus_if.hi), 64'd0);
    check_output("abort_lo", 64'(bus_if.lo), 64'd0);
    @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) pulses++;
    end
    check_output("abort_no_done", 64'(pulses), 64'd0);
    check_output("abort_lo_after", 64'(bus_if.lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
